dual_port_ram_arbiter: RTL

- Shares one DualPortRam instance (external, same clock on WClk/RClk) between two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
- Independent round-robin arbitration on the RAM write port and the read port, with a req/gnt handshake per requester.
- Read responses are steered back to the winning requester with a registered valid, matching the RAM's 1-cycle read latency.

---
 rtl/dual_port_ram_arbiter_pkg.sv | 15 +
 rtl/dual_port_ram_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/dual_port_ram_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/dual_port_ram_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM arbiter and its RAM instance.
package dual_port_ram_arbiter_pkg;

    localparam int REQ_NUM            = 2;
    localparam int PTR_W              = $clog2(REQ_NUM);
    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 6;

    // Round-robin pointer: which requester wins when both ask at once.
    typedef enum logic [PTR_W-1:0] {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_e;

endpackage

// File: rtl/dual_port_ram_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; grant is combinational from req and pointer.
module rr_arbiter2
    import dual_port_ram_arbiter_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic [REQ_NUM-1:0] i_req,
    output logic [REQ_NUM-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_ptr
);

    ptr_e               r_ptr;
    ptr_e               w_ptr_next;
    logic [REQ_NUM-1:0] w_gnt;

    always_comb begin
        w_gnt      = 2'b00;
        w_ptr_next = r_ptr;
        if (i_req == 2'b11) begin
            w_gnt = (r_ptr == PTR_REQ1) ? 2'b10 : 2'b01;
        end else begin
            w_gnt = i_req;
        end
        // The loser of this cycle gets priority next time.
        if (w_gnt[0]) begin
            w_ptr_next = PTR_REQ1;
        end else if (w_gnt[1]) begin
            w_ptr_next = PTR_REQ0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_ptr <= PTR_REQ0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_gnt = w_gnt;
    assign o_ptr = r_ptr;

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Shares one read-before-write dual-port RAM between two requesters with
// independent round-robin arbitration on the write and read ports.
module dual_port_ram_arbiter
    import dual_port_ram_arbiter_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int AddrWidth = DEFAULT_ADDR_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    // Handshake: a transfer happens in any cycle with Req && Gnt. Gnt is
    // combinational from Req; the requester holds Req/Addr/Data until granted.
    input  logic                 WReq0,
    input  logic                 WReq1,
    input  logic [AddrWidth-1:0] WAddr0,
    input  logic [AddrWidth-1:0] WAddr1,
    input  logic [DataWidth-1:0] WData0,
    input  logic [DataWidth-1:0] WData1,
    output logic                 WGnt0,
    output logic                 WGnt1,
    input  logic                 RReq0,
    input  logic                 RReq1,
    input  logic [AddrWidth-1:0] RAddr0,
    input  logic [AddrWidth-1:0] RAddr1,
    output logic                 RGnt0,
    output logic                 RGnt1,
    output logic                 RValid0,
    output logic                 RValid1,
    output logic [DataWidth-1:0] RData,
    output logic                 RamWEnc,
    output logic [AddrWidth-1:0] RamWAddr,
    output logic [DataWidth-1:0] RamWData,
    output logic                 RamREnc,
    output logic [AddrWidth-1:0] RamRAddr,
    input  logic [DataWidth-1:0] RamRData,
    output logic [PTR_W-1:0]     DbgWPtr,
    output logic [PTR_W-1:0]     DbgRPtr
);

    logic [REQ_NUM-1:0] w_wgnt;
    logic [REQ_NUM-1:0] w_rgnt;
    logic [REQ_NUM-1:0] r_rvalid;

    rr_arbiter2 u_warb (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_req ({WReq1, WReq0}),
        .o_gnt (w_wgnt),
        .o_ptr (DbgWPtr)
    );

    rr_arbiter2 u_rarb (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_req ({RReq1, RReq0}),
        .o_gnt (w_rgnt),
        .o_ptr (DbgRPtr)
    );

    assign WGnt0    = w_wgnt[0];
    assign WGnt1    = w_wgnt[1];
    assign RGnt0    = w_rgnt[0];
    assign RGnt1    = w_rgnt[1];

    assign RamWEnc  = |w_wgnt;
    assign RamWAddr = w_wgnt[1] ? WAddr1 : WAddr0;
    assign RamWData = w_wgnt[1] ? WData1 : WData0;
    assign RamREnc  = |w_rgnt;
    assign RamRAddr = w_rgnt[1] ? RAddr1 : RAddr0;

    // Valid tracks the RAM's one-cycle read latency; data is passed straight through.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_rgnt;
        end
    end

    assign RValid0 = r_rvalid[0];
    assign RValid1 = r_rvalid[1];
    assign RData   = RamRData;

endmodule
